// File: rtl/ps2_scancode_decoder.sv
// Purpose : assemble PS/2 set-2 byte streams into key events, queue them, track lock LEDs.
// Latency : terminal byte strobed at edge k is in the FIFO and ev_valid is high after edge k.
// Backpres: ev_valid/ev_ready pop; a push into a full FIFO is dropped and sets sticky overflow.
//
// Ports:
//   CLOCK_50, reset          clock and asynchronous active-high reset
//   key_action, scan_code    byte input, one byte per rising edge of key_action
//   ev_valid/ev_ready        first-word fall-through event head and pop handshake
//   ev_code/ev_ext/ev_break  head event: code with prefixes stripped, E0 flag, F0 flag
//   overflow/overflow_clr    sticky drop flag and its synchronous clear
//   ps2_lock_control         [0] Scroll, [1] Num, [2] Caps lock state
// Build option: define PS2_TYPEMATIC_FILTER_EN to suppress autorepeat makes with a
// 512-entry held-key map indexed by {ext, code}.

module ps2_event_fifo #(
    parameter int W     = 10,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         wr_vld,
    input  logic [W-1:0] wr_dat,
    output logic         wr_rdy,
    output logic         rd_vld,
    input  logic         rd_rdy,
    output logic [W-1:0] rd_dat
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [W-1:0] mem [DEPTH];
    logic         empty;
    logic         full;
    logic         pop;
    logic         push;

    assign empty  = (wr_ptr == rd_ptr);
    assign full   = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign rd_vld = ~empty;
    assign pop    = rd_vld & rd_rdy;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_rdy = ~full | pop;
    assign push   = wr_vld & wr_rdy;
    // Head reads as zero while empty so the outputs have a defined idle value.
    assign rd_dat = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_dat;
    end
endmodule

module ps2_scancode_decoder #(
    parameter int DEPTH   = 8,
    parameter int PAUSE_N = 7
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic       key_action,
    input  logic [7:0] scan_code,
    output logic       ev_valid,
    input  logic       ev_ready,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       overflow,
    input  logic       overflow_clr,
    output logic [2:0] ps2_lock_control
);
    localparam int CW = $clog2(PAUSE_N + 1);

    typedef struct packed {
        logic [7:0] code;
        logic       ext;
        logic       brk;
    } ev_t;

    typedef enum logic [1:0] {ST_IDLE, ST_PFX, ST_PAUSE} state_t;

    state_t        state, state_n;
    logic          ext_p, ext_n;
    logic          brk_p, brk_n;
    logic [CW-1:0] cnt, cnt_n;
    logic          act_d;
    logic          strb;
    logic          key_vld;     // terminal byte completes a key event
    logic          pause_vld;   // last swallowed byte of the Pause sequence
    logic          suppress;
    logic          fifo_wr_vld;
    logic          fifo_wr_rdy;
    ev_t           fifo_wr_dat;
    ev_t           head;
    logic [2:0]    lock_hit;
    logic [2:0]    lock_held;
    logic [2:0]    lock_q;

    assign strb = key_action & ~act_d;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            // Held high: a key_action asserted through reset must not look like an edge.
            act_d <= 1'b1;
            state <= ST_IDLE;
            ext_p <= 1'b0;
            brk_p <= 1'b0;
            cnt   <= '0;
        end else begin
            act_d <= key_action;
            state <= state_n;
            ext_p <= ext_n;
            brk_p <= brk_n;
            cnt   <= cnt_n;
        end
    end

    always_comb begin
        state_n   = state;
        ext_n     = ext_p;
        brk_n     = brk_p;
        cnt_n     = cnt;
        key_vld   = 1'b0;
        pause_vld = 1'b0;
        case (state)
            ST_IDLE, ST_PFX: begin
                if (strb) begin
                    case (scan_code)
                        8'hE0: begin
                            ext_n   = 1'b1;
                            state_n = ST_PFX;
                        end
                        8'hF0: begin
                            brk_n   = 1'b1;
                            state_n = ST_PFX;
                        end
                        8'hE1: begin
                            ext_n   = 1'b0;
                            brk_n   = 1'b0;
                            cnt_n   = CW'(PAUSE_N);
                            state_n = ST_PAUSE;
                        end
                        // Keyboard status/response bytes, never key codes.
                        8'hAA, 8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: begin
                            ext_n   = 1'b0;
                            brk_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                        default: begin
                            key_vld = 1'b1;
                            ext_n   = 1'b0;
                            brk_n   = 1'b0;
                            state_n = ST_IDLE;
                        end
                    endcase
                end
            end
            ST_PAUSE: begin
                if (strb) begin
                    cnt_n = cnt - CW'(1);
                    if (cnt == CW'(1)) begin
                        pause_vld = 1'b1;
                        state_n   = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    // Lock keys: Scroll 7E, Num 77, Caps 58, non-extended only.
    assign lock_hit = {scan_code == 8'h58, scan_code == 8'h77, scan_code == 8'h7E};

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            lock_held <= '0;
            lock_q    <= '0;
        end else if (key_vld && !ext_p) begin
            for (int i = 0; i < 3; i++) begin
                if (lock_hit[i]) begin
                    if (brk_p) begin
                        lock_held[i] <= 1'b0;
                    end else begin
                        // Only the first make of a held key toggles; repeats are ignored.
                        if (!lock_held[i]) lock_q[i] <= ~lock_q[i];
                        lock_held[i] <= 1'b1;
                    end
                end
            end
        end
    end

    assign ps2_lock_control = lock_q;

`ifdef PS2_TYPEMATIC_FILTER_EN
    logic [511:0] held_map;
    logic [8:0]   held_idx;

    assign held_idx = {ext_p, scan_code};
    assign suppress = key_vld & ~brk_p & held_map[held_idx];

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            held_map <= '0;
        end else if (key_vld) begin
            held_map[held_idx] <= ~brk_p;
        end
    end
`else
    assign suppress = 1'b0;
`endif

    // Pause has no break code, so it bypasses the typematic filter.
    assign fifo_wr_vld = (key_vld & ~suppress) | pause_vld;
    assign fifo_wr_dat = pause_vld ? ev_t'{code: 8'hE1, ext: 1'b0, brk: 1'b0}
                                   : ev_t'{code: scan_code, ext: ext_p, brk: brk_p};

    ps2_event_fifo #(
        .W     ($bits(ev_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (CLOCK_50),
        .rst    (reset),
        .wr_vld (fifo_wr_vld),
        .wr_dat (fifo_wr_dat),
        .wr_rdy (fifo_wr_rdy),
        .rd_vld (ev_valid),
        .rd_rdy (ev_ready),
        .rd_dat (head)
    );

    assign ev_code  = head.code;
    assign ev_ext   = head.ext;
    assign ev_break = head.brk;

    // A drop wins over a clear in the same cycle.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            overflow <= 1'b0;
        end else if (fifo_wr_vld && !fifo_wr_rdy) begin
            overflow <= 1'b1;
        end else if (overflow_clr) begin
            overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_scancode_decoder.sv
module tb_ps2_scancode_decoder;
    localparam int DEPTH = 8;
`ifdef PS2_TYPEMATIC_FILTER_EN
    localparam bit FILT = 1'b1;
`else
    localparam bit FILT = 1'b0;
`endif

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic       key_action = 1'b0;
    logic [7:0] scan_code = 8'h00;
    logic       ev_valid;
    logic       ev_ready = 1'b0;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       overflow;
    logic       overflow_clr = 1'b0;
    logic [2:0] ps2_lock_control;

    int checks = 0;
    int failures = 0;

    always #5 CLOCK_50 = ~CLOCK_50;

    ps2_scancode_decoder #(.DEPTH(DEPTH), .PAUSE_N(7)) dut (
        .CLOCK_50         (CLOCK_50),
        .reset            (reset),
        .key_action       (key_action),
        .scan_code        (scan_code),
        .ev_valid         (ev_valid),
        .ev_ready         (ev_ready),
        .ev_code          (ev_code),
        .ev_ext           (ev_ext),
        .ev_break         (ev_break),
        .overflow         (overflow),
        .overflow_clr     (overflow_clr),
        .ps2_lock_control (ps2_lock_control)
    );

    typedef struct {
        logic [7:0] b;
        logic       vld;
        logic [7:0] code;
        logic       ext;
        logic       brk;
        logic [2:0] lock;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic [7:0] b, input logic vld, input logic [7:0] code,
                                input logic ext, input logic brk, input logic [2:0] lock);
        vec_t v;
        v.b = b; v.vld = vld; v.code = code; v.ext = ext; v.brk = brk; v.lock = lock;
        tbl.push_back(v);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Present one byte; returns 1ns after the edge that consumes it.
    task automatic send(input logic [7:0] b);
        @(posedge CLOCK_50); #1;
        scan_code  = b;
        key_action = 1'b1;
        @(posedge CLOCK_50); #1;
        key_action = 1'b0;
    endtask

    task automatic pop();
        ev_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        ev_ready = 1'b0;
    endtask

    initial begin
        // Test 1: basic make / break
        add(8'h1C, 1, 8'h1C, 0, 0, 3'b000);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b000);
        add(8'h1C, 1, 8'h1C, 0, 1, 3'b000);
        // Test 2: extended keys, prefix order
        add(8'hE0, 0, 8'h00, 0, 0, 3'b000);
        add(8'h75, 1, 8'h75, 1, 0, 3'b000);
        add(8'hE0, 0, 8'h00, 0, 0, 3'b000);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b000);
        add(8'h75, 1, 8'h75, 1, 1, 3'b000);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b000);
        add(8'hE0, 0, 8'h00, 0, 0, 3'b000);
        add(8'h75, 1, 8'h75, 1, 1, 3'b000);
        // Status bytes discarded and clear pending prefixes
        add(8'hAA, 0, 8'h00, 0, 0, 3'b000);
        add(8'hE0, 0, 8'h00, 0, 0, 3'b000);
        add(8'hFA, 0, 8'h00, 0, 0, 3'b000);
        add(8'h1C, 1, 8'h1C, 0, 0, 3'b000);
        // Test 3: Caps lock with typematic repeats
        add(8'h58, 1,     8'h58, 0, 0, 3'b100);
        add(8'h58, !FILT, 8'h58, 0, 0, 3'b100);
        add(8'h58, !FILT, 8'h58, 0, 0, 3'b100);
        add(8'hF0, 0,     8'h00, 0, 0, 3'b100);
        add(8'h58, 1,     8'h58, 0, 1, 3'b100);
        add(8'h58, 1,     8'h58, 0, 0, 3'b000);
        // Num / Scroll, extended make does not toggle
        add(8'h77, 1, 8'h77, 0, 0, 3'b010);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b010);
        add(8'h77, 1, 8'h77, 0, 1, 3'b010);
        add(8'hE0, 0, 8'h00, 0, 0, 3'b010);
        add(8'h7E, 1, 8'h7E, 1, 0, 3'b010);
        add(8'h7E, 1, 8'h7E, 0, 0, 3'b011);
        // Test 5: Pause sequence, Num inside it is swallowed
        add(8'hE1, 0, 8'h00, 0, 0, 3'b011);
        add(8'h14, 0, 8'h00, 0, 0, 3'b011);
        add(8'h77, 0, 8'h00, 0, 0, 3'b011);
        add(8'hE1, 0, 8'h00, 0, 0, 3'b011);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b011);
        add(8'h14, 0, 8'h00, 0, 0, 3'b011);
        add(8'hF0, 0, 8'h00, 0, 0, 3'b011);
        add(8'h77, 1, 8'hE1, 0, 0, 3'b011);

        repeat (2) @(posedge CLOCK_50);
        #1 reset = 1'b0;

        chk("rst_valid", ev_valid, 0);
        chk("rst_code", ev_code, 0);
        chk("rst_ext", ev_ext, 0);
        chk("rst_break", ev_break, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_lock", ps2_lock_control, 0);

        for (int i = 0; i < tbl.size(); i++) begin
            send(tbl[i].b);
            chk($sformatf("v%0d_valid", i), ev_valid, tbl[i].vld);
            chk($sformatf("v%0d_lock", i), ps2_lock_control, tbl[i].lock);
            if (tbl[i].vld) begin
                chk($sformatf("v%0d_code", i), ev_code, tbl[i].code);
                chk($sformatf("v%0d_ext", i), ev_ext, tbl[i].ext);
                chk($sformatf("v%0d_break", i), ev_break, tbl[i].brk);
                pop();
                chk($sformatf("v%0d_drained", i), ev_valid, 0);
            end
        end

        // Test 4: overflow with consumer stalled
        for (int i = 0; i < DEPTH + 2; i++) begin
            send(8'h10 + 8'(i));
            if (i == DEPTH - 1) chk("ovf_not_yet", overflow, 0);
        end
        chk("ovf_set", overflow, 1);
        for (int i = 0; i < DEPTH; i++) begin
            chk($sformatf("drain%0d_valid", i), ev_valid, 1);
            chk($sformatf("drain%0d_code", i), ev_code, 8'h10 + 8'(i));
            pop();
        end
        chk("drain_empty", ev_valid, 0);
        overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1;
        overflow_clr = 1'b0;
        chk("ovf_cleared", overflow, 0);

        // Drop and clear in the same cycle: overflow stays set
        for (int i = 0; i < DEPTH; i++) send(8'h20 + 8'(i));
        chk("full_no_ovf", overflow, 0);
        @(posedge CLOCK_50); #1;
        scan_code = 8'h2B; key_action = 1'b1; overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1;
        key_action = 1'b0; overflow_clr = 1'b0;
        chk("drop_beats_clr", overflow, 1);
        overflow_clr = 1'b1;
        @(posedge CLOCK_50); #1;
        overflow_clr = 1'b0;
        chk("clr_after_drop", overflow, 0);

        // Full FIFO with simultaneous pop and push: push accepted
        @(posedge CLOCK_50); #1;
        scan_code = 8'h2A; key_action = 1'b1; ev_ready = 1'b1;
        @(posedge CLOCK_50); #1;
        key_action = 1'b0; ev_ready = 1'b0;
        chk("poppush_no_ovf", overflow, 0);
        for (int i = 1; i < DEPTH; i++) begin
            chk($sformatf("pp%0d_code", i), ev_code, 8'h20 + 8'(i));
            pop();
        end
        chk("pp_last_valid", ev_valid, 1);
        chk("pp_last_code", ev_code, 8'h2A);
        pop();
        chk("pp_empty", ev_valid, 0);

        // Pop while empty is ignored; push with ready high on empty is push only
        ev_ready = 1'b1;
        repeat (2) @(posedge CLOCK_50);
        #1;
        send(8'h1C);
        chk("empty_push_valid", ev_valid, 1);
        chk("empty_push_code", ev_code, 8'h1C);
        @(posedge CLOCK_50); #1;
        ev_ready = 1'b0;
        chk("empty_push_popped", ev_valid, 0);

        // Test 6: reset mid-sequence with events queued
        send(8'h31);
        send(8'h32);
        send(8'h33);
        chk("pre_rst_valid", ev_valid, 1);
        chk("pre_rst_lock", ps2_lock_control, 3'b011);
        send(8'hE0);
        @(posedge CLOCK_50); #1;
        reset = 1'b1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        chk("mid_rst_valid", ev_valid, 0);
        chk("mid_rst_lock", ps2_lock_control, 0);
        chk("mid_rst_code", ev_code, 0);
        send(8'h75);
        chk("post_rst_valid", ev_valid, 1);
        chk("post_rst_code", ev_code, 8'h75);
        chk("post_rst_ext", ev_ext, 0);
        chk("post_rst_break", ev_break, 0);
        pop();

        // key_action held high across reset gives no strobe
        @(posedge CLOCK_50); #1;
        scan_code = 8'h16; key_action = 1'b1; reset = 1'b1;
        @(posedge CLOCK_50); #1;
        reset = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("held_act_no_event", ev_valid, 0);
        key_action = 1'b0;
        repeat (2) @(posedge CLOCK_50);
        #1;
        chk("held_act_release", ev_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
